// File: rtl/ql_ram_arbiter_if.sv
// Bus bundle between the CPU/video requesters, refresh tick, SDRAM controller and ql_ram_arbiter.
// slave = arbiter's view; master = environment (requesters + SDRAM controller) view.
interface ql_ram_arbiter_if #(
  parameter int AW = 24
);
  logic          cpu_req;
  logic          cpu_we;
  logic [1:0]    cpu_be;
  logic [AW-1:0] cpu_addr;
  logic [15:0]   cpu_wdata;
  logic [15:0]   cpu_rdata;
  logic          cpu_ack;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [15:0]   vid_rdata;
  logic          vid_ack;
  logic          ref_req;
  logic          ram_req;
  logic          ram_we;
  logic [1:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_wdata;
  logic          ram_refresh;
  logic [15:0]   ram_rdata;
  logic          ram_ready;
  logic [1:0]    owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  vid_req, vid_addr,
    output vid_rdata, vid_ack,
    input  ref_req,
    output ram_req, ram_we, ram_be, ram_addr, ram_wdata, ram_refresh,
    input  ram_rdata, ram_ready,
    output owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output vid_req, vid_addr,
    input  vid_rdata, vid_ack,
    output ref_req,
    input  ram_req, ram_we, ram_be, ram_addr, ram_wdata, ram_refresh,
    output ram_rdata, ram_ready,
    input  owner
  );
endinterface

// File: rtl/ql_ram_arbiter.sv
// Single-port SDRAM arbiter for CPU, video fetch and refresh; one transaction in flight.
// Optional CPU wait-cycle statistics counter enabled by defining QL_ARB_STATS_EN.
module ql_ram_arbiter #(
  parameter int AW           = 24,
  parameter int CPU_MAX_WAIT = 4,
  parameter int REF_MAX      = 3
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  ql_ram_arbiter_if.slave bus,
  input  logic            stats_clr,
  output logic [15:0]     cpu_wait
);
  localparam int RCW = $clog2(REF_MAX + 1);
  localparam int SCW = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [RCW-1:0] REF_FULL    = RCW'(REF_MAX);
  localparam logic [SCW-1:0] STREAK_FULL = SCW'(CPU_MAX_WAIT);
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_VID  = 2'b10;
  localparam logic [1:0] OWN_REF  = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state;
  logic [RCW-1:0] ref_cnt;
  logic [SCW-1:0] vid_streak;
  logic [1:0]     gnt;
  logic [AW-1:0]  gnt_addr;
  logic           gnt_cpu;
  logic           gnt_vid;
  logic           gnt_ref;

  function automatic logic [RCW-1:0] ref_sat_inc(input logic [RCW-1:0] v);
    return (v == REF_FULL) ? v : v + RCW'(1);
  endfunction

  function automatic logic [SCW-1:0] streak_sat_inc(input logic [SCW-1:0] v);
    return (v == STREAK_FULL) ? v : v + SCW'(1);
  endfunction

  // Urgent refresh beats everything; a starved CPU beats video; idle-time refresh is last.
  always_comb begin
    gnt = OWN_NONE;
    if (ref_cnt == REF_FULL)                             gnt = OWN_REF;
    else if (bus.cpu_req && (vid_streak == STREAK_FULL)) gnt = OWN_CPU;
    else if (bus.vid_req)                                gnt = OWN_VID;
    else if (bus.cpu_req)                                gnt = OWN_CPU;
    else if (ref_cnt != '0)                              gnt = OWN_REF;
  end

  assign gnt_cpu  = (state == IDLE) && (gnt == OWN_CPU);
  assign gnt_vid  = (state == IDLE) && (gnt == OWN_VID);
  assign gnt_ref  = (state == IDLE) && (gnt == OWN_REF);
  assign gnt_addr = (gnt == OWN_VID) ? bus.vid_addr : bus.cpu_addr;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ref_cnt    <= '0;
      vid_streak <= '0;
    end else begin
      if (bus.ref_req && !gnt_ref)      ref_cnt <= ref_sat_inc(ref_cnt);
      else if (!bus.ref_req && gnt_ref) ref_cnt <= ref_cnt - RCW'(1);
      if (!bus.cpu_req || gnt_cpu)      vid_streak <= '0;
      else if (gnt_vid)                 vid_streak <= streak_sat_inc(vid_streak);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      bus.ram_req     <= 1'b0;
      bus.ram_we      <= 1'b0;
      bus.ram_be      <= 2'b00;
      bus.ram_addr    <= '0;
      bus.ram_wdata   <= '0;
      bus.ram_refresh <= 1'b0;
      bus.owner       <= OWN_NONE;
      bus.cpu_ack     <= 1'b0;
      bus.vid_ack     <= 1'b0;
      bus.cpu_rdata   <= '0;
      bus.vid_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt != OWN_NONE) begin
            state           <= BUSY;
            bus.ram_req     <= 1'b1;
            bus.owner       <= gnt;
            bus.ram_refresh <= (gnt == OWN_REF);
            bus.ram_we      <= (gnt == OWN_CPU) && bus.cpu_we;
            bus.ram_be      <= (gnt == OWN_CPU) ? bus.cpu_be : 2'b11;
            bus.ram_addr    <= gnt_addr;
            bus.ram_wdata   <= bus.cpu_wdata;
          end
        end
        BUSY: begin
          if (bus.ram_ready) begin
            state           <= DONE;
            bus.ram_req     <= 1'b0;
            bus.ram_refresh <= 1'b0;
            if (bus.owner == OWN_CPU) begin
              bus.cpu_ack   <= 1'b1;
              bus.cpu_rdata <= bus.ram_rdata;
            end
            if (bus.owner == OWN_VID) begin
              bus.vid_ack   <= 1'b1;
              bus.vid_rdata <= bus.ram_rdata;
            end
          end
        end
        DONE: begin
          state       <= IDLE;
          bus.owner   <= OWN_NONE;
          bus.cpu_ack <= 1'b0;
          bus.vid_ack <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef QL_ARB_STATS_EN
  logic [15:0] cpu_wait_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                        cpu_wait_q <= '0;
    else if (stats_clr)                  cpu_wait_q <= '0;
    else if (bus.cpu_req && !bus.cpu_ack) cpu_wait_q <= sat_inc16(cpu_wait_q);
  end

  assign cpu_wait = cpu_wait_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign cpu_wait         = '0;
`endif

endmodule

// File: tb/tb_ql_ram_arbiter.sv
// Directed bench for ql_ram_arbiter with a small SDRAM responder and grant/ack monitor.
module tb_ql_ram_arbiter;
  localparam int AW = 24;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        stats_clr;
  logic [15:0] cpu_wait;

  ql_ram_arbiter_if #(.AW(AW)) bus ();

  ql_ram_arbiter #(.AW(AW), .CPU_MAX_WAIT(4), .REF_MAX(3)) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .bus      (bus),
    .stats_clr(stats_clr),
    .cpu_wait (cpu_wait)
  );

  always #5 clk_sys = ~clk_sys;

  int          n_cmp = 0;
  int          n_err = 0;
  bit          stall = 1'b0;
  int          lat = 3;
  logic [15:0] rd_val = 16'h0000;
  logic [2:0]  grants[$];
  int          cpu_acks = 0;
  int          vid_acks = 0;
  bit          req_prev = 1'b0;

  // SDRAM responder: ram_ready lat cycles after ram_req's first cycle, frozen while stalled.
  initial begin
    int cnt;
    cnt = 0;
    bus.ram_ready = 1'b0;
    bus.ram_rdata = 16'h0000;
    forever begin
      @(negedge clk_sys);
      if (!bus.ram_req) begin
        cnt = 0;
        bus.ram_ready = 1'b0;
      end else if (stall) begin
        bus.ram_ready = 1'b0;
      end else begin
        cnt++;
        bus.ram_ready = (cnt == lat + 1);
        bus.ram_rdata = rd_val;
      end
    end
  end

  // Grant log {refresh, owner} at each ram_req rise; ack pulse counters.
  initial begin
    forever begin
      @(posedge clk_sys);
      #1;
      if (bus.ram_req && !req_prev) grants.push_back({bus.ram_refresh, bus.owner});
      req_prev = bus.ram_req;
      if (bus.cpu_ack) cpu_acks++;
      if (bus.vid_ack) vid_acks++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // which: 0 = cpu_ack, 1 = vid_ack, otherwise ram_req
  task automatic wait_sig(input int which, input int bound, output int cycles);
    logic hit;
    cycles = 0;
    hit = 1'b0;
    while (!hit && cycles < bound) begin
      @(negedge clk_sys);
      cycles++;
      case (which)
        0:       hit = bus.cpu_ack;
        1:       hit = bus.vid_ack;
        default: hit = bus.ram_req;
      endcase
    end
    check($sformatf("wait%0d_seen", which), 32'(hit), 32'd1);
  endtask

  function automatic logic [2:0] grant_at(input int idx);
    return (idx < grants.size()) ? grants[idx] : 3'bxxx;
  endfunction

  logic [2:0] exp_order [10] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001,
                                 3'b010, 3'b010, 3'b010, 3'b010, 3'b001};
  logic [2:0] exp_ref6  [4]  = '{3'b111, 3'b010, 3'b111, 3'b111};

  initial begin
    int cyc;
    int base;
    int ca0;
    int va0;
    logic [15:0] exp_wait;

    reset_n       = 1'b0;
    stats_clr     = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_be    = 2'b11;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = 16'h0000;
    bus.vid_req   = 1'b0;
    bus.vid_addr  = '0;
    bus.ref_req   = 1'b0;

    repeat (3) @(negedge clk_sys);
    check("rst_ram_req", 32'(bus.ram_req), 32'd0);
    check("rst_owner",   32'(bus.owner),   32'd0);
    check("rst_acks",    32'({bus.cpu_ack, bus.vid_ack}), 32'd0);
    check("rst_cpu_wait", 32'(cpu_wait), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // CPU read, 3-cycle SDRAM latency
    ca0 = cpu_acks;
    lat = 3; rd_val = 16'h1234;
    bus.cpu_we = 1'b0; bus.cpu_be = 2'b11; bus.cpu_addr = 24'h000100; bus.cpu_req = 1'b1;
    wait_sig(0, 20, cyc);
    check("t1_latency",   32'(cyc), 32'd5);
    check("t1_cpu_rdata", 32'(bus.cpu_rdata), 32'h1234);
    check("t1_owner",     32'(bus.owner), 32'd1);
    bus.cpu_req = 1'b0;
    repeat (4) @(negedge clk_sys);
    check("t1_ack_count", 32'(cpu_acks - ca0), 32'd1);
    check("t1_owner_idle", 32'(bus.owner), 32'd0);

    // CPU write: request fields forwarded to SDRAM
    lat = 2;
    bus.cpu_we = 1'b1; bus.cpu_be = 2'b10; bus.cpu_addr = 24'h00ABCD; bus.cpu_wdata = 16'h5A5A;
    bus.cpu_req = 1'b1;
    wait_sig(2, 20, cyc);
    check("t2_ram_we",    32'(bus.ram_we), 32'd1);
    check("t2_ram_be",    32'(bus.ram_be), 32'd2);
    check("t2_ram_addr",  32'(bus.ram_addr), 32'h00ABCD);
    check("t2_ram_wdata", 32'(bus.ram_wdata), 32'h5A5A);
    check("t2_ram_refresh", 32'(bus.ram_refresh), 32'd0);
    wait_sig(0, 20, cyc);
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_be = 2'b11;
    repeat (2) @(negedge clk_sys);

    // Video read, then CPU read: video rdata held across CPU transaction
    rd_val = 16'hBEEF;
    bus.vid_addr = 24'h003000; bus.vid_req = 1'b1;
    wait_sig(2, 20, cyc);
    check("t3_vid_owner", 32'(bus.owner), 32'd2);
    check("t3_vid_we_be", 32'({bus.ram_we, bus.ram_be}), 32'b011);
    check("t3_vid_addr",  32'(bus.ram_addr), 32'h003000);
    wait_sig(1, 20, cyc);
    check("t3_vid_rdata", 32'(bus.vid_rdata), 32'hBEEF);
    bus.vid_req = 1'b0;
    @(negedge clk_sys);
    rd_val = 16'h4321;
    bus.cpu_addr = 24'h000200; bus.cpu_req = 1'b1;
    wait_sig(0, 20, cyc);
    check("t3_cpu_rdata",  32'(bus.cpu_rdata), 32'h4321);
    check("t3_vid_hold",   32'(bus.vid_rdata), 32'hBEEF);
    bus.cpu_req = 1'b0;
    repeat (3) @(negedge clk_sys);

    // CPU and video held together: starvation guard
    lat = 1;
    base = grants.size(); ca0 = cpu_acks; va0 = vid_acks;
    bus.cpu_req = 1'b1; bus.vid_req = 1'b1;
    cyc = 0;
    while (grants.size() < base + 10 && cyc < 300) begin
      @(negedge clk_sys);
      cyc++;
    end
    bus.cpu_req = 1'b0; bus.vid_req = 1'b0;
    repeat (12) @(negedge clk_sys);
    check("t4_grant_count", 32'(grants.size() - base), 32'd10);
    for (int i = 0; i < 10; i++)
      check($sformatf("t4_grant%0d", i), 32'(grant_at(base + i)), 32'(exp_order[i]));
    check("t4_cpu_acks", 32'(cpu_acks - ca0), 32'd2);
    check("t4_vid_acks", 32'(vid_acks - va0), 32'd8);

    // Five refresh ticks while SDRAM is stalled on a CPU read: pending count saturates at 3
    lat = 3; stall = 1'b1; rd_val = 16'h7777;
    bus.cpu_req = 1'b1;
    wait_sig(2, 20, cyc);
    repeat (5) begin
      bus.ref_req = 1'b1;
      @(negedge clk_sys);
    end
    bus.ref_req = 1'b0;
    base = grants.size(); ca0 = cpu_acks; va0 = vid_acks;
    stall = 1'b0;
    wait_sig(0, 20, cyc);
    bus.cpu_req = 1'b0;
    repeat (40) @(negedge clk_sys);
    check("t5_ref_grants", 32'(grants.size() - base), 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("t5_grant%0d", i), 32'(grant_at(base + i)), 32'b111);
    check("t5_cpu_acks", 32'(cpu_acks - ca0), 32'd1);
    check("t5_vid_acks", 32'(vid_acks - va0), 32'd0);

    // Urgent refresh ahead of pending CPU and video
    stall = 1'b1;
    bus.cpu_req = 1'b1;
    wait_sig(2, 20, cyc);
    bus.vid_req = 1'b1;
    repeat (3) begin
      bus.ref_req = 1'b1;
      @(negedge clk_sys);
    end
    bus.ref_req = 1'b0;
    base = grants.size();
    stall = 1'b0;
    wait_sig(0, 20, cyc);
    cyc = 0;
    while (grants.size() < base + 2 && cyc < 50) begin
      @(negedge clk_sys);
      cyc++;
    end
    bus.cpu_req = 1'b0; bus.vid_req = 1'b0;
    repeat (40) @(negedge clk_sys);
    check("t6_grant_count", 32'(grants.size() - base), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t6_grant%0d", i), 32'(grant_at(base + i)), 32'(exp_ref6[i]));

    // Asynchronous reset while BUSY, then pending CPU request is granted again
    stall = 1'b1; rd_val = 16'h0A0A;
    bus.cpu_req = 1'b1;
    wait_sig(2, 20, cyc);
    reset_n = 1'b0;
    #1;
    check("t7_ram_req",   32'(bus.ram_req), 32'd0);
    check("t7_owner",     32'(bus.owner), 32'd0);
    check("t7_acks",      32'({bus.cpu_ack, bus.vid_ack}), 32'd0);
    check("t7_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
    @(negedge clk_sys);
    stall = 1'b0;
    reset_n = 1'b1;
    wait_sig(0, 30, cyc);
    check("t7_regrant_owner", 32'(bus.owner), 32'd1);
    check("t7_regrant_rdata", 32'(bus.cpu_rdata), 32'h0A0A);
    bus.cpu_req = 1'b0;
    repeat (3) @(negedge clk_sys);

    // CPU wait-cycle statistics: 5-cycle latency gives 7 waiting cycles
`ifdef QL_ARB_STATS_EN
    exp_wait = 16'd7;
`else
    exp_wait = 16'd0;
`endif
    stats_clr = 1'b1;
    @(negedge clk_sys);
    stats_clr = 1'b0;
    lat = 5;
    bus.cpu_req = 1'b1;
    wait_sig(0, 30, cyc);
    bus.cpu_req = 1'b0;
    check("t8_cpu_wait", 32'(cpu_wait), 32'(exp_wait));
    stats_clr = 1'b1;
    @(negedge clk_sys);
    stats_clr = 1'b0;
    check("t8_cpu_wait_clr", 32'(cpu_wait), 32'd0);
    repeat (3) @(negedge clk_sys);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
